// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the single-port data memory.
// The arbiter takes the slave modport; requesters and the memory side take the master modport.
interface dmem_arbiter_if #(
    parameter int DATA_W = 32
);
    logic              req0_valid;
    logic              req0_we;
    logic [31:0]       req0_addr;
    logic [DATA_W-1:0] req0_wdata;
    logic              req0_ready;
    logic              req0_done;
    logic [DATA_W-1:0] req0_rdata;
    logic              req0_err;

    logic              req1_valid;
    logic              req1_we;
    logic [31:0]       req1_addr;
    logic [DATA_W-1:0] req1_wdata;
    logic              req1_ready;
    logic              req1_done;
    logic [DATA_W-1:0] req1_rdata;
    logic              req1_err;

    logic [31:0]       mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_read;
    logic              mem_write;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  req0_valid, req0_we, req0_addr, req0_wdata,
        output req0_ready, req0_done, req0_rdata, req0_err,
        input  req1_valid, req1_we, req1_addr, req1_wdata,
        output req1_ready, req1_done, req1_rdata, req1_err,
        output mem_addr, mem_wdata, mem_read, mem_write,
        input  mem_rdata
    );

    modport master (
        output req0_valid, req0_we, req0_addr, req0_wdata,
        input  req0_ready, req0_done, req0_rdata, req0_err,
        output req1_valid, req1_we, req1_addr, req1_wdata,
        input  req1_ready, req1_done, req1_rdata, req1_err,
        input  mem_addr, mem_wdata, mem_read, mem_write,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin two-port sequencer in front of a single-port data memory.
// One access in flight: accept (IDLE) -> strobe memory (ACCESS) -> report done (RESP).
module dmem_arbiter #(
    parameter int DEPTH  = 256,
    parameter int DATA_W = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    dmem_arbiter_if.slave  bus
);
    localparam int NUM_PORTS = 2;

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

    typedef struct packed {
        logic              we;
        logic [31:0]       addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

    state_t                                r_state;
    state_t                                w_next;
    logic                                  r_rr_last;
    logic                                  r_owner;
    req_t                                  r_req;

    logic [NUM_PORTS-1:0]                  w_valid;
    req_t [NUM_PORTS-1:0]                  w_req;
    logic                                  w_any;
    logic                                  w_win;
    logic                                  w_in_range;
    logic [DATA_W-1:0]                     w_capture;

    logic [NUM_PORTS-1:0]                  w_ready;
    logic [NUM_PORTS-1:0]                  w_done;
    logic [NUM_PORTS-1:0]                  w_err;
    logic [NUM_PORTS-1:0][DATA_W-1:0]      w_rdata;
    logic                                  w_mem_read;
    logic                                  w_mem_write;
    logic [31:0]                           w_mem_addr;
    logic [DATA_W-1:0]                     w_mem_wdata;

    assign w_valid  = {bus.req1_valid, bus.req0_valid};
    assign w_req[0] = '{we: bus.req0_we, addr: bus.req0_addr, wdata: bus.req0_wdata};
    assign w_req[1] = '{we: bus.req1_we, addr: bus.req1_addr, wdata: bus.req1_wdata};
    assign w_any    = |w_valid;

    // On a tie the port that did not win last time goes first.
    always_comb begin
        if (w_valid == 2'b11) w_win = ~r_rr_last;
        else                  w_win = w_valid[1];
    end

    // Full-width compare so out-of-range addresses never alias into the array.
    assign w_in_range = (r_req.addr < 32'(DEPTH));
    assign w_capture  = (!r_req.we && w_in_range) ? bus.mem_rdata : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_any) w_next = S_ACCESS;
            S_ACCESS: w_next = S_RESP;
            S_RESP:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Strobes are decoded from the state register so an async reset drops them at once.
    always_comb begin
        w_ready     = '0;
        w_done      = '0;
        w_err       = '0;
        w_mem_read  = 1'b0;
        w_mem_write = 1'b0;
        w_mem_addr  = '0;
        w_mem_wdata = '0;
        case (r_state)
            S_IDLE: begin
                if (rst_n && w_any) w_ready[w_win] = 1'b1;
            end
            S_ACCESS: begin
                w_mem_addr  = r_req.addr;
                w_mem_wdata = r_req.wdata;
                w_mem_read  = ~r_req.we & w_in_range;
                w_mem_write =  r_req.we & w_in_range;
            end
            S_RESP: begin
                w_done[r_owner] = 1'b1;
                w_err[r_owner]  = ~w_in_range;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_last <= 1'b1;
            r_owner   <= 1'b0;
            r_req     <= '0;
        end else if (r_state == S_IDLE && w_any) begin
            r_rr_last <= w_win;
            r_owner   <= w_win;
            r_req     <= w_req[w_win];
        end
    end

    // Each port keeps its own read-data register; only the owner's is overwritten.
    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        logic [DATA_W-1:0] r_rdata;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                r_rdata <= '0;
            else if (r_state == S_ACCESS && r_owner == 1'(p))
                r_rdata <= w_capture;
        end
        assign w_rdata[p] = r_rdata;
    end

    assign bus.req0_ready = w_ready[0];
    assign bus.req0_done  = w_done[0];
    assign bus.req0_err   = w_err[0];
    assign bus.req0_rdata = w_rdata[0];
    assign bus.req1_ready = w_ready[1];
    assign bus.req1_done  = w_done[1];
    assign bus.req1_err   = w_err[1];
    assign bus.req1_rdata = w_rdata[1];
    assign bus.mem_addr   = w_mem_addr;
    assign bus.mem_wdata  = w_mem_wdata;
    assign bus.mem_read   = w_mem_read;
    assign bus.mem_write  = w_mem_write;

endmodule
